// File: rtl/alu_16_if.sv
// Switch/result bundle for the demo-board ALU: opcode and operand-step switches in, result out.
interface alu_16_if #(
    parameter int WIDTH = 16
);
    logic               SW1;
    logic               SW2;
    logic               SW15;
    logic               SW16;
    logic [2*WIDTH-1:0] ans;

    modport master (output SW1, output SW2, output SW15, output SW16, input ans);
    modport slave  (input SW1, input SW2, input SW15, input SW16, output ans);
endinterface

// File: rtl/alu_16.sv
// Board-level ALU: two switch-stepped operand registers, ADD/SUB/MULT/RSHIFT into a registered result.
// Define ALU16_SIGNED_EN for two's-complement operands (sign-extended results, arithmetic shift).
module alu_16 #(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] A_INIT = 16'h00F0,
    parameter logic [WIDTH-1:0] B_INIT = 16'h0003
) (
    input  logic     CLK100MHZ,
    input  logic     SW4,
    alu_16_if.slave  io
);
    localparam int RW  = 2 * WIDTH;
    localparam int SHW = $clog2(RW);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_SHR = 2'b11
    } op_e;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sw15_q, sw16_q;
    logic [RW-1:0]    ans_q, ans_d;
    logic [RW-1:0]    a_x, b_x;
    logic [SHW-1:0]   sh;
    op_e              op;

    assign op = op_e'({io.SW2, io.SW1});
    assign sh = b_q[SHW-1:0];

    // Operands widened once; the signed build only changes the extension and the shift kind.
`ifdef ALU16_SIGNED_EN
    assign a_x = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_x = {{WIDTH{b_q[WIDTH-1]}}, b_q};
`else
    assign a_x = {{WIDTH{1'b0}}, a_q};
    assign b_x = {{WIDTH{1'b0}}, b_q};
`endif

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (io.SW15 && !sw15_q) a_d = a_q + WIDTH'(1);
        if (io.SW16 && !sw16_q) b_d = b_q + WIDTH'(1);
    end

    // Shift amounts up to RW-1 naturally flush a WIDTH-bit operand to zero / all sign bits.
    always_comb begin
        ans_d = '0;
        case (op)
            OP_ADD: ans_d = a_x + b_x;
            OP_SUB: ans_d = a_x - b_x;
            OP_MUL: ans_d = a_x * b_x;
            OP_SHR: begin
`ifdef ALU16_SIGNED_EN
                ans_d = $signed(a_x) >>> sh;
`else
                ans_d = a_x >> sh;
`endif
            end
            default: ans_d = '0;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge SW4) begin
        if (!SW4) begin
            a_q    <= A_INIT;
            b_q    <= B_INIT;
            sw15_q <= 1'b0;
            sw16_q <= 1'b0;
            ans_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            sw15_q <= io.SW15;
            sw16_q <= io.SW16;
            ans_q  <= ans_d;
        end
    end

    assign io.ans = ans_q;
endmodule

// File: tb/tb_alu_16.sv
// Scoreboard bench for alu_16: expected results queued at stimulus time, popped after each edge.
module tb_alu_16;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_16_if bus ();
    alu_16_if bus2 ();

    alu_16 dut (.CLK100MHZ(clk), .SW4(rst_n), .io(bus));
    alu_16 #(.A_INIT(16'hFFFE)) dut2 (.CLK100MHZ(clk), .SW4(rst_n), .io(bus2));

    int checks = 0;
    int errors = 0;
    logic [15:0] ma, mb;
    logic        p15, p16;
    logic [31:0] sb[$];
    logic [31:0] exp_v;

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sbv, r;
        int unsigned ua, ub;
        int unsigned s;
        s = 32'(b[4:0]);
`ifdef ALU16_SIGNED_EN
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        case (op)
            2'b00: r = sa + sbv;
            2'b01: r = sa - sbv;
            2'b10: r = sa * sbv;
            default: r = (s >= 16) ? (a[15] ? -1 : 0) : (sa >>> s);
        endcase
        return 32'(r);
`else
        sa = 0; sbv = 0; r = 0;
        ua = 32'(a);
        ub = 32'(b);
        case (op)
            2'b00: return ua + ub;
            2'b01: return ua - ub;
            2'b10: return ua * ub;
            default: return (s >= 16) ? 32'h0 : (ua >> s);
        endcase
`endif
    endfunction

    task automatic model_reset();
        ma = 16'h00F0; mb = 16'h0003; p15 = 1'b0; p16 = 1'b0;
        sb.delete();
    endtask

    // Queue the result of the coming edge, advance the model, then step one clock.
    task automatic tick();
        sb.push_back(ref_alu({bus.SW2, bus.SW1}, ma, mb));
        if (bus.SW15 && !p15) ma = ma + 16'd1;
        if (bus.SW16 && !p16) mb = mb + 16'd1;
        p15 = bus.SW15;
        p16 = bus.SW16;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        {bus.SW2, bus.SW1, bus.SW15, bus.SW16} = 4'b0;
        {bus2.SW2, bus2.SW1, bus2.SW15, bus2.SW16} = 4'b0;
        model_reset();
        #1;
        checks++; if (bus.ans !== 32'h0) begin errors++; $display("FAIL reset_ans: got %h want 0", bus.ans); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        tick();
        exp_v = sb.pop_front();
        checks++; if (bus.ans !== exp_v || bus.ans !== 32'h000000F3) begin errors++; $display("FAIL reset_first_add: got %h want %h", bus.ans, exp_v); end
        {bus.SW2, bus.SW1} = 2'b10;
        tick();
        exp_v = sb.pop_front();
        checks++; if (bus.ans !== exp_v) begin errors++; $display("FAIL pre_reset_mult: got %h want %h", bus.ans, exp_v); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.ans !== 32'h0) begin errors++; $display("FAIL async_reset: got %h want 0", bus.ans); end
        rst_n = 1'b1;
        model_reset();
        {bus.SW2, bus.SW1} = 2'b00;
        tick();
        exp_v = sb.pop_front();
        checks++; if (bus.ans !== 32'h000000F3) begin errors++; $display("FAIL post_reset_add: got %h want %h", bus.ans, 32'h000000F3); end
    endtask

    task automatic test_ops();
        logic [31:0] tbl [4];
        tbl[0] = 32'hF3; tbl[1] = 32'hED; tbl[2] = 32'h2D0; tbl[3] = 32'h1E;
        for (int op = 0; op < 4; op++) begin
            {bus.SW2, bus.SW1} = 2'(op);
            tick();
            exp_v = sb.pop_front();
            checks++; if (bus.ans !== exp_v || bus.ans !== tbl[op]) begin errors++; $display("FAIL op%0d: got %h want %h", op, bus.ans, tbl[op]); end
        end
    endtask

    task automatic test_step_b();
        {bus.SW2, bus.SW1} = 2'b00;
        bus.SW16 = 1'b1; tick();
        exp_v = sb.pop_front();
        checks++; if (bus.ans !== exp_v) begin errors++; $display("FAIL stepb_edge1: got %h want %h", bus.ans, exp_v); end
        bus.SW16 = 1'b0; tick();
        exp_v = sb.pop_front();
        checks++; if (bus.ans !== exp_v || bus.ans !== 32'hF4) begin errors++; $display("FAIL stepb_pulse: got %h want f4", bus.ans); end
        bus.SW16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_v = sb.pop_front();
            checks++; if (bus.ans !== exp_v) begin errors++; $display("FAIL stepb_hold%0d: got %h want %h", i, bus.ans, exp_v); end
        end
        bus.SW16 = 1'b0; tick();
        exp_v = sb.pop_front();
        checks++; if (bus.ans !== 32'hF5) begin errors++; $display("FAIL stepb_once: got %h want f5", bus.ans); end
    endtask

    task automatic test_sub_wrap();
        int n;
        {bus.SW2, bus.SW1} = 2'b01;
        n = 0;
        while (mb != 16'h0100 && n < 400) begin
            bus.SW16 = 1'b1; tick();
            exp_v = sb.pop_front();
            if (bus.ans !== exp_v) begin checks++; errors++; $display("FAIL subwrap_step: got %h want %h", bus.ans, exp_v); end
            bus.SW16 = 1'b0; tick();
            exp_v = sb.pop_front();
            if (bus.ans !== exp_v) begin checks++; errors++; $display("FAIL subwrap_step: got %h want %h", bus.ans, exp_v); end
            n++;
        end
        checks++; if (bus.ans !== 32'hFFFFFFF0) begin errors++; $display("FAIL sub_wrap: got %h want fffffff0", bus.ans); end
    endtask

    task automatic test_both_shift();
        pulse_reset();
        {bus.SW2, bus.SW1} = 2'b00;
        {bus.SW15, bus.SW16} = 2'b11; tick();
        exp_v = sb.pop_front();
        {bus.SW15, bus.SW16} = 2'b00; tick();
        exp_v = sb.pop_front();
        checks++; if (bus.ans !== exp_v || bus.ans !== 32'hF5) begin errors++; $display("FAIL both_step: got %h want f5", bus.ans); end
        {bus.SW2, bus.SW1} = 2'b11; tick();
        exp_v = sb.pop_front();
        checks++; if (bus.ans !== exp_v || bus.ans !== 32'h0F) begin errors++; $display("FAIL shr4: got %h want 0f", bus.ans); end
        for (int i = 0; i < 12; i++) begin
            bus.SW16 = 1'b1; tick();
            exp_v = sb.pop_front();
            bus.SW16 = 1'b0; tick();
            exp_v = sb.pop_front();
            checks++; if (bus.ans !== exp_v) begin errors++; $display("FAIL shr_step%0d: got %h want %h", i, bus.ans, exp_v); end
        end
        checks++; if (bus.ans !== 32'h0) begin errors++; $display("FAIL shr16: got %h want 0", bus.ans); end
    endtask

    task automatic test_a_wrap();
        logic [31:0] w0, w1;
`ifdef ALU16_SIGNED_EN
        w0 = 32'h1; w1 = 32'h2;
`else
        w0 = 32'h10001; w1 = 32'h10002;
`endif
        pulse_reset();
        {bus2.SW2, bus2.SW1, bus2.SW15} = 3'b000;
        tick(); exp_v = sb.pop_front();
        checks++; if (bus2.ans !== w0) begin errors++; $display("FAIL awrap_init: got %h want %h", bus2.ans, w0); end
        bus2.SW15 = 1'b1; tick(); exp_v = sb.pop_front();
        bus2.SW15 = 1'b0; tick(); exp_v = sb.pop_front();
        checks++; if (bus2.ans !== w1) begin errors++; $display("FAIL awrap_ffff: got %h want %h", bus2.ans, w1); end
        bus2.SW15 = 1'b1; tick(); exp_v = sb.pop_front();
        bus2.SW15 = 1'b0; tick(); exp_v = sb.pop_front();
        checks++; if (bus2.ans !== 32'h3) begin errors++; $display("FAIL awrap_zero: got %h want 3", bus2.ans); end
        checks++; if (bus.ans !== exp_v) begin errors++; $display("FAIL awrap_main: got %h want %h", bus.ans, exp_v); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_step_b();
        test_sub_wrap();
        test_both_shift();
        test_a_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
